// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_LINES = 4;
    localparam int CODE_W    = 4;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    // Lowest-index column pulled low; only meaningful when at least one bit is 0.
    function automatic logic [1:0] lowest_low(input logic [NUM_LINES-1:0] col);
        lowest_low = 2'd0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (!col[i]) begin
                lowest_low = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/key_scan_timer.sv
// Free-running divider: OUT_tick is high for one cycle out of every SCAN_DIV.
module key_scan_timer #(
    parameter int SCAN_DIV = 1000
) (
    input  logic IN_clk,
    input  logic IN_rst,
    output logic OUT_tick
);

    localparam int            CW   = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign OUT_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = OUT_tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge IN_clk) begin
        if (IN_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with press/release debounce and a one-cycle key strobe.
// Auto-repeat while held is built only with KEYPAD_KEY_REPEAT_EN defined.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEB_TICKS    = 8,
    parameter int REPEAT_TICKS = 64
) (
    input  logic                  IN_clk,
    input  logic                  IN_rst,
    input  logic [NUM_LINES-1:0]  IN_col,
    output logic [NUM_LINES-1:0]  OUT_row,
    output logic [CODE_W-1:0]     OUT_value,
    output logic                  OUT_key,
    output logic                  OUT_held
);

    if (SCAN_DIV < 2 || DEB_TICKS < 2 || REPEAT_TICKS < 2) begin : g_bad_params
        $error("keypad_scan_ctrl: SCAN_DIV, DEB_TICKS and REPEAT_TICKS must be >= 2");
    end

    localparam int               CNT_W   = $clog2(DEB_TICKS + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_TICKS);

    logic tick;

    key_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .IN_clk  (IN_clk),
        .IN_rst  (IN_rst),
        .OUT_tick(tick)
    );

    state_t              state_q, state_d;
    logic [1:0]          row_q, row_d;
    logic [1:0]          col_q, col_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                key_q, key_d;
    logic [CODE_W-1:0]   value_q, value_d;
    logic                key_dn;

`ifdef KEYPAD_KEY_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_TICKS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] rep_q, rep_d;
`endif

    // Only the captured column is watched once a press is seen.
    assign key_dn = !IN_col[col_q];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        key_d   = 1'b0;
        value_d = value_q;
`ifdef KEYPAD_KEY_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (&IN_col) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d   = lowest_low(IN_col);
                        cnt_d   = CNT_W'(1);
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (key_dn) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == DEB_MAX) begin
                            cnt_d   = '0;
                            key_d   = 1'b1;
                            value_d = {row_q, col_q};
                            state_d = ST_HELD;
`ifdef KEYPAD_KEY_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        cnt_d   = '0;
                        row_d   = row_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!key_dn) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RELEASE;
                    end
`ifdef KEYPAD_KEY_REPEAT_EN
                    else if (rep_q == REP_LAST) begin
                        key_d = 1'b1;
                        rep_d = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (key_dn) begin
                        cnt_d   = '0;
                        state_d = ST_HELD;
`ifdef KEYPAD_KEY_REPEAT_EN
                        rep_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == DEB_MAX) begin
                            cnt_d   = '0;
                            row_d   = row_q + 2'd1;
                            state_d = ST_SCAN;
                        end
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge IN_clk) begin
        if (IN_rst) begin
            state_q <= ST_SCAN;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            key_q   <= 1'b0;
            value_q <= '0;
`ifdef KEYPAD_KEY_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            value_q <= value_d;
`ifdef KEYPAD_KEY_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign OUT_row   = ~(4'b0001 << row_q);
    assign OUT_value = value_q;
    assign OUT_key   = key_q;
    assign OUT_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEB_TICKS=3, REPEAT_TICKS=5.
module tb_keypad_scan_ctrl;

`ifdef KEYPAD_KEY_REPEAT_EN
    localparam int REP_ON = 1;
`else
    localparam int REP_ON = 0;
`endif

    logic        IN_clk = 1'b0;
    logic        IN_rst;
    logic [3:0]  IN_col;
    logic [3:0]  OUT_row;
    logic [3:0]  OUT_value;
    logic        OUT_key;
    logic        OUT_held;

    logic [15:0] keys;
    int          checks   = 0;
    int          failures = 0;
    int          strobes  = 0;
    int          bad_row  = 0;
    int          s0;
    logic [3:0]  last_val = 4'h0;

    always #5 IN_clk = ~IN_clk;

    keypad_scan_ctrl #(
        .SCAN_DIV    (4),
        .DEB_TICKS   (3),
        .REPEAT_TICKS(5)
    ) dut (
        .IN_clk   (IN_clk),
        .IN_rst   (IN_rst),
        .IN_col   (IN_col),
        .OUT_row  (OUT_row),
        .OUT_value(OUT_value),
        .OUT_key  (OUT_key),
        .OUT_held (OUT_held)
    );

    // Physical keypad: a pressed key shorts its column low while its row is driven.
    always_comb begin
        IN_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !OUT_row[r]) begin
                    IN_col[c] = 1'b0;
                end
            end
        end
    end

    always @(posedge IN_clk) begin
        #1;
        if (OUT_key) begin
            strobes++;
            last_val = OUT_value;
        end
        if ($countones(~OUT_row) != 1) begin
            bad_row++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge IN_clk);
    endtask

    task automatic ticks(input int n);
        step(4 * n);
    endtask

    initial begin
        IN_rst = 1'b1;
        keys   = 16'h0;
        step(3);
        check("rst_row",   OUT_row,   4'b1110);
        check("rst_key",   OUT_key,   1'b0);
        check("rst_value", OUT_value, 4'h0);
        check("rst_held",  OUT_held,  1'b0);
        IN_rst = 1'b0;

        // Idle scan
        ticks(1);
        check("idle_row1", OUT_row, 4'b1101);
        step(2);
        check("idle_row1_mid", OUT_row, 4'b1101);
        step(2);
        check("idle_row2", OUT_row, 4'b1011);
        ticks(1);
        check("idle_row3", OUT_row, 4'b0111);
        ticks(1);
        check("idle_wrap", OUT_row, 4'b1110);
        check("idle_nostrobe", strobes, 0);

        // Row2/col1 pressed and held
        s0 = strobes;
        keys[9] = 1'b1;
        ticks(4);
        check("r2c1_debouncing_held", OUT_held, 1'b0);
        check("r2c1_debouncing_key",  OUT_key,  1'b0);
        ticks(1);
        check("r2c1_key",   OUT_key,   1'b1);
        check("r2c1_value", OUT_value, 4'h9);
        check("r2c1_held",  OUT_held,  1'b1);
        step(1);
        check("r2c1_key_one_cycle", OUT_key, 1'b0);
        step(3);
        ticks(6);
        check("r2c1_strobes", strobes - s0, 1 + REP_ON);
        check("r2c1_lastval", last_val, 4'h9);
        keys = 16'h0;
        ticks(2);
        check("r2c1_release2_held", OUT_held, 1'b1);
        ticks(1);
        check("r2c1_released", OUT_held, 1'b0);
        check("r2c1_next_row", OUT_row, 4'b0111);
        check("r2c1_no_rel_strobe", strobes - s0, 1 + REP_ON);

        // Row1/col3 glitch shorter than the debounce window
        s0 = strobes;
        keys[7] = 1'b1;
        ticks(2);
        check("glitch_row1", OUT_row, 4'b1101);
        ticks(2);
        check("glitch_row_hold", OUT_row, 4'b1101);
        check("glitch_held", OUT_held, 1'b0);
        keys = 16'h0;
        ticks(1);
        check("glitch_resume_row2", OUT_row, 4'b1011);
        check("glitch_nostrobe", strobes - s0, 0);

        // Two keys on row3: lowest column wins, the other is ignored
        s0 = strobes;
        keys[12] = 1'b1;
        keys[14] = 1'b1;
        ticks(4);
        check("dual_key",   OUT_key,   1'b1);
        check("dual_value", OUT_value, 4'hC);
        keys[14] = 1'b0;
        ticks(4);
        check("dual_col2_release_held", OUT_held, 1'b1);
        check("dual_strobes", strobes - s0, 1);
        keys[12] = 1'b0;
        ticks(3);
        check("dual_released", OUT_held, 1'b0);
        check("dual_next_row", OUT_row, 4'b1110);

        // Release bounce on row0/col2
        s0 = strobes;
        keys[2] = 1'b1;
        ticks(3);
        check("bounce_value", OUT_value, 4'h2);
        keys = 16'h0;
        ticks(1);
        check("bounce_rel1_held", OUT_held, 1'b1);
        keys[2] = 1'b1;
        ticks(1);
        check("bounce_back_held", OUT_held, 1'b1);
        keys = 16'h0;
        ticks(2);
        check("bounce_rel2_held", OUT_held, 1'b1);
        ticks(1);
        check("bounce_released", OUT_held, 1'b0);
        check("bounce_next_row", OUT_row, 4'b1101);
        check("bounce_strobes", strobes - s0, 1);

        // Reset landing on a tick edge during debounce
        s0 = strobes;
        keys[5] = 1'b1;
        ticks(1);
        check("rstdeb_row_before", OUT_row, 4'b1101);
        step(3);
        IN_rst = 1'b1;
        step(1);
        check("rstdeb_row",  OUT_row,  4'b1110);
        check("rstdeb_held", OUT_held, 1'b0);
        check("rstdeb_key",  OUT_key,  1'b0);
        IN_rst = 1'b0;
        step(1);
        check("rstdeb_key_after", OUT_key, 1'b0);
        step(3);
        check("rstdeb_rescan_row1", OUT_row, 4'b1101);
        check("rstdeb_nostrobe", strobes - s0, 0);
        ticks(3);
        check("rstdeb_fresh_key",   OUT_key,   1'b1);
        check("rstdeb_fresh_value", OUT_value, 4'h5);
        keys = 16'h0;
        ticks(3);
        check("rstdeb_released", OUT_held, 1'b0);
        check("rstdeb_final_row", OUT_row, 4'b1011);

        check("row_onehot_violations", bad_row, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
